ncl_alu_bridge: RTL
===================

Name: ncl_alu_bridge

Overview:
- Synchronous-to-dual-rail bridge placed directly upstream of the 4-bit dual-rail (NULL Convention) ALU.
- Accepts single-rail operands over a valid/ready handshake and encodes them as a DATA wavefront.
- Detects ALU completion, captures the result, then drives NULL and waits for the ALU outputs to return to all-NULL.
- Returns the single-rail result and flags over a second valid/ready handshake, with a per-phase timeout and illegal-code detection.

Parameters:
- WIDTH, 4: operand width in bits; the dual-rail buses are 2*WIDTH.
- SYNC_STAGES, 2: flop depth for synchronising the asynchronous detect signals (minimum 2).
- TIMEOUT, 64: maximum cycles allowed in any wait phase before an error is raised.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  bridge idle; transfer occurs when in_valid and in_ready are both high
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  1  0 = add, 1 = subtract
- alu_a  out  2*WIDTH  dual-rail A to the ALU
- alu_b  out  2*WIDTH  dual-rail B to the ALU
- alu_opr  out  2  dual-rail operation select
- alu_soma  in  2*WIDTH  dual-rail result from the ALU
- alu_of  in  2  dual-rail overflow flag
- alu_neg  in  2  dual-rail negative flag
- alu_zero  in  2  dual-rail zero flag
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_sum  out  WIDTH  single-rail result
- out_of  out  1  overflow flag
- out_neg  out  1  negative flag
- out_zero  out  1  zero flag
- out_err  out  1  this transaction timed out or saw an illegal code
- fault  out  1  sticky hard fault; cleared only by reset

Behaviour:
- Dual-rail encoding per bit pair [2i+1:2i]:
  - 2'b10 = logic 1
  - 2'b01 = logic 0
  - 2'b00 = NULL
  - 2'b11 = illegal
- Raw detects are combinational on the ALU inputs, then pass through SYNC_STAGES flops:
  - complete = every pair of soma/of/neg/zero holds exactly one high rail.
  - allnull = all 14 input bits are 0.
  - illegal = any pair equals 2'b11.
- State machine: INIT, IDLE, DATA, NULLP, RESP, ERRN, FAULT.
  - Reset: state = INIT; all alu_* = 0 (NULL); out_* = 0; in_ready = 0; fault = 0.
  - INIT: drive NULL. On sync allnull go to IDLE.
  - IDLE: in_ready = 1. On transfer, register the operands, drive the DATA wavefront, go to DATA.
  - DATA: hold DATA.
    - sync illegal: go to ERRN (illegal has priority over complete in the same cycle).
    - else sync complete: capture the raw ALU outputs, decoded to single rail, into the result register; drive NULL; go to NULLP.
    - Raw ALU outputs are stable because the ALU holds DATA until NULL is presented.
  - NULLP: drive NULL. On sync allnull go to RESP.
  - RESP: out_valid = 1 with result and out_err held stable. On out_ready go to IDLE and drop out_valid.
  - ERRN: drive NULL; set the result register to 0 and out_err = 1. On sync allnull go to RESP.
- Timeout:
  - Counter clears on every state change and counts in INIT, DATA, NULLP and ERRN.
  - Reaching TIMEOUT in DATA goes to ERRN.
  - Reaching TIMEOUT in INIT, NULLP or ERRN goes to FAULT.
  - FAULT: drive NULL, fault = 1, in_ready = 0, out_valid = 0 until reset.
- Latency with a zero-delay ALU: in_valid/in_ready handshake at edge T, out_valid high after edge T + 2*(SYNC_STAGES+1), which is 6 cycles at the defaults.
- in_ready is 0 in every state except IDLE, so only one transaction is in flight.
- Reset mid-operation: alu_* return to NULL immediately and asynchronously; any pending result is discarded; the FSM re-enters INIT.
- ALU outputs change only on a wavefront, so the multi-bit capture happens only after complete is synchronised.

Decomposition:
- Header ncl_defs.vh holds:
  - dual-rail code constants (DR_ONE, DR_ZERO, DR_NULL, DR_ILL);
  - state encodings;
  - operation codes (OP_ADD = 0, OP_SUB = 1).
- Sub-module ncl_sync: parameterised SYNC_STAGES-deep single-bit synchroniser with asynchronous active-low reset to 0. Three instances: complete, allnull, illegal.

Test Plan:
- Add, zero-delay behavioural ALU: in_a=3, in_b=3, in_op=0.
  - alu_a = 8'b01011010, alu_opr = 2'b01.
  - out_valid 6 cycles after the handshake with out_sum=6, of=0, neg=0, zero=0, out_err=0.
- Subtract: in_a=5, in_b=5, in_op=1.
  - alu_opr = 2'b10.
  - out_sum=0, out_zero=1; alu_* all-zero before out_valid.
- Backpressure: out_ready=0 for 10 cycles.
  - out_valid and the result hold steady; in_ready=0.
  - A new in_valid is not accepted until the cycle after the out_ready handshake.
- ALU model that never completes.
  - After TIMEOUT cycles in DATA, alu_* go to NULL.
  - Response with out_err=1, out_sum=0; a following add then succeeds normally.
- Illegal code: model drives alu_of=2'b11 during DATA.
  - ERRN entered, out_err=1.
  - Separately, a model that stays non-NULL sets fault=1 after TIMEOUT cycles in NULLP; fault persists until rst_n is pulsed.
- Assert rst_n=0 mid-DATA.
  - alu_* = 0 with no clock edge; out_valid=0; in_ready=0.
  - After release, INIT then IDLE with in_ready=1 once the ALU outputs are NULL.

Source files
------------

// File: rtl/ncl_alu_bridge_pkg.sv
// ncl_alu_bridge_pkg: dual-rail codes, op codes, FSM states and the bit encoder shared by the bridge
package ncl_alu_bridge_pkg;
  localparam logic [1:0] DR_ONE  = 2'b10;
  localparam logic [1:0] DR_ZERO = 2'b01;
  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_ILL  = 2'b11;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_DATA, S_NULLP, S_RESP, S_ERRN, S_FAULT} state_t;
  function automatic logic [1:0] dr_enc(input logic b);
    return b ? DR_ONE : DR_ZERO;
  endfunction
endpackage

// File: rtl/ncl_alu_bridge_if.sv
// ncl_alu_bridge_if: operand/result handshakes, dual-rail ALU bus and fault flag
// slave = bridge side, master = environment (producer, ALU, consumer)
interface ncl_alu_bridge_if #(parameter int WIDTH = 4);
  logic in_valid, in_ready, in_op;
  logic [WIDTH-1:0] in_a, in_b;
  logic [2*WIDTH-1:0] alu_a, alu_b, alu_soma;
  logic [1:0] alu_opr, alu_of, alu_neg, alu_zero;
  logic out_valid, out_ready, out_of, out_neg, out_zero, out_err, fault;
  logic [WIDTH-1:0] out_sum;
  modport slave (
    input in_valid, in_a, in_b, in_op, alu_soma, alu_of, alu_neg, alu_zero, out_ready,
    output in_ready, alu_a, alu_b, alu_opr, out_valid, out_sum, out_of, out_neg, out_zero, out_err, fault
  );
  modport master (
    output in_valid, in_a, in_b, in_op, alu_soma, alu_of, alu_neg, alu_zero, out_ready,
    input in_ready, alu_a, alu_b, alu_opr, out_valid, out_sum, out_of, out_neg, out_zero, out_err, fault
  );
endinterface

// File: rtl/ncl_alu_bridge_sync.sv
// ncl_alu_bridge_sync: STAGES-deep single-bit synchroniser, async active-low reset to 0
// ports: clk, rst_n, i_d (async input), o_q (synchronised output)
module ncl_alu_bridge_sync #(parameter int STAGES = 2) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_ff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ff <= '0;
    else r_ff <= {r_ff[STAGES-2:0], i_d};
  assign o_q = r_ff[STAGES-1];
endmodule

// File: rtl/ncl_alu_bridge.sv
// ncl_alu_bridge: single-rail valid/ready to dual-rail NCL ALU bridge with completion detect and timeout
// ports: clk, rst_n (async active-low), bus (ncl_alu_bridge_if.slave: operand in, ALU dual-rail, result out, fault)
module ncl_alu_bridge
  import ncl_alu_bridge_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input logic clk,
  input logic rst_n,
  ncl_alu_bridge_if.slave bus
);
  localparam int NP = WIDTH + 3;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [2*WIDTH-1:0] r_a, r_b;
  logic [1:0] r_opr;
  logic [WIDTH-1:0] r_sum;
  logic r_of, r_neg, r_zero, r_err, r_in_ready, r_out_valid, r_fault;
  logic [2*NP-1:0] w_dr;
  logic [NP-1:0] w_one, w_ill;
  logic [2*WIDTH-1:0] w_enc_a, w_enc_b;
  logic [WIDTH-1:0] w_sum;
  logic w_complete, w_allnull, w_illegal, w_s_complete, w_s_allnull, w_s_illegal, w_tout;
  assign w_dr = {bus.alu_soma, bus.alu_of, bus.alu_neg, bus.alu_zero};
  for (genvar i = 0; i < NP; i++) begin : g_pair
    assign w_one[i] = ^w_dr[2*i+:2];
    assign w_ill[i] = w_dr[2*i+:2] == DR_ILL;
  end
  for (genvar j = 0; j < WIDTH; j++) begin : g_bit
    assign w_enc_a[2*j+:2] = dr_enc(bus.in_a[j]);
    assign w_enc_b[2*j+:2] = dr_enc(bus.in_b[j]);
    assign w_sum[j] = bus.alu_soma[2*j+1];
  end
  assign w_complete = &w_one;
  assign w_allnull  = ~|w_dr;
  assign w_illegal  = |w_ill;
  ncl_alu_bridge_sync #(.STAGES(SYNC_STAGES)) u_sync_complete (.clk(clk), .rst_n(rst_n), .i_d(w_complete), .o_q(w_s_complete));
  ncl_alu_bridge_sync #(.STAGES(SYNC_STAGES)) u_sync_allnull  (.clk(clk), .rst_n(rst_n), .i_d(w_allnull),  .o_q(w_s_allnull));
  ncl_alu_bridge_sync #(.STAGES(SYNC_STAGES)) u_sync_illegal  (.clk(clk), .rst_n(rst_n), .i_d(w_illegal),  .o_q(w_s_illegal));
  assign w_tout = r_cnt == CW'(TIMEOUT - 1);
  // Raw ALU outputs are sampled only once completion has been synchronised; they hold DATA until NULL is sent.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_a         <= {WIDTH{DR_NULL}};
      r_b         <= {WIDTH{DR_NULL}};
      r_opr       <= DR_NULL;
      r_sum       <= '0;
      r_of        <= 1'b0;
      r_neg       <= 1'b0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
      case (r_state)
        S_INIT, S_NULLP, S_ERRN:
          if (w_s_allnull) begin
            r_cnt       <= '0;
            r_state     <= r_state == S_INIT ? S_IDLE : S_RESP;
            r_in_ready  <= r_state == S_INIT;
            r_out_valid <= r_state != S_INIT;
          end else if (w_tout) begin
            r_cnt   <= '0;
            r_state <= S_FAULT;
            r_fault <= 1'b1;
          end
        S_IDLE: begin
          r_cnt <= '0;
          if (bus.in_valid) begin
            r_a        <= w_enc_a;
            r_b        <= w_enc_b;
            r_opr      <= dr_enc(bus.in_op == OP_SUB);
            r_in_ready <= 1'b0;
            r_state    <= S_DATA;
          end
        end
        S_DATA:
          if (w_s_illegal || w_s_complete || w_tout) begin
            r_cnt   <= '0;
            r_a     <= {WIDTH{DR_NULL}};
            r_b     <= {WIDTH{DR_NULL}};
            r_opr   <= DR_NULL;
            r_state <= w_s_illegal || !w_s_complete ? S_ERRN : S_NULLP;
            r_err   <= w_s_illegal || !w_s_complete;
            r_sum   <= w_s_illegal || !w_s_complete ? '0 : w_sum;
            r_of    <= !w_s_illegal && w_s_complete && bus.alu_of[1];
            r_neg   <= !w_s_illegal && w_s_complete && bus.alu_neg[1];
            r_zero  <= !w_s_illegal && w_s_complete && bus.alu_zero[1];
          end
        S_RESP: begin
          r_cnt <= '0;
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  assign bus.in_ready  = r_in_ready;
  assign bus.alu_a     = r_a;
  assign bus.alu_b     = r_b;
  assign bus.alu_opr   = r_opr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_sum;
  assign bus.out_of    = r_of;
  assign bus.out_neg   = r_neg;
  assign bus.out_zero  = r_zero;
  assign bus.out_err   = r_err;
  assign bus.fault     = r_fault;
endmodule
